crc_bram_engine: RTL and testbench

Parametrised CRC engine that walks a byte-wide block RAM and computes a configurable CRC (width, polynomial, init, reflection, final XOR) over a programmable address window. It succeeds the fixed CRC-16/CCITT BRAM reader and adds:
- programmable start address and length, with address wrap;
- configurable BRAM read latency;
- abort;
- a single-cycle completion pulse.

It sits between a packet buffer BRAM and the frame-check logic.

---
 rtl/crc_pkg.sv | 29 ++
 rtl/crc_byte_lfsr.sv | 34 +++
 rtl/crc_bram_engine.sv | 193 +++++++++++++++++++
 tb/tb_crc_bram_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC BRAM engine: FSM state encoding,
// common polynomial/seed values and a bit-reverse helper.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } crc_state_e;

    localparam int unsigned CRC_MAX_W = 32;

    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT = 16'hFFFF;
    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [CRC_MAX_W-1:0] bit_rev(input logic [CRC_MAX_W-1:0] v,
                                                     input int unsigned w);
        logic [CRC_MAX_W-1:0] r;
        for (int i = 0; i < CRC_MAX_W; i++) begin
            r[CRC_MAX_W-1-i] = v[i];
        end
        return r >> (CRC_MAX_W - w);
    endfunction

endpackage

// File: rtl/crc_byte_lfsr.sv
// Combinational single-byte CRC step: MSB-first LFSR over 8 bit times, data
// XORed into the top byte, optional input-byte reflection.
module crc_byte_lfsr
    import crc_pkg::*;
#(
    parameter int unsigned          CRC_W = 16,
    parameter logic [CRC_W-1:0]     POLY  = CRC_W'(CRC16_CCITT_POLY),
    parameter bit                   REFIN = 1'b0
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic [7:0]       i_data,
    output logic [CRC_W-1:0] o_crc_c
);

    logic [7:0]       w_byte;
    logic [CRC_W-1:0] w_crc;

    always_comb begin
        w_byte = i_data;
        if (REFIN) begin
            w_byte = 8'(bit_rev(CRC_MAX_W'(i_data), 8));
        end
        w_crc = i_crc ^ (CRC_W'(w_byte) << (CRC_W - 8));
        for (int i = 0; i < 8; i++) begin
            if (w_crc[CRC_W-1]) begin
                w_crc = (w_crc << 1) ^ POLY;
            end else begin
                w_crc = w_crc << 1;
            end
        end
        o_crc_c = w_crc;
    end

endmodule

// File: rtl/crc_bram_engine.sv
// Walks a byte-wide BRAM over a wrapping address window and computes a
// configurable CRC. Optional CRC_CHECK_EN adds i_expected / o_match.
module crc_bram_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(CRC16_CCITT_POLY),
    parameter logic [CRC_W-1:0] INIT   = CRC_W'(CRC16_CCITT_INIT),
    parameter logic [CRC_W-1:0] XOROUT = '0,
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0,
    parameter int unsigned      ADDR_W = 9,
    parameter int unsigned      RD_LAT = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [CRC_W-1:0]  o_crc,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_en,
    input  logic [7:0]        i_bram_dout
`ifdef CRC_CHECK_EN
    ,
    input  logic [CRC_W-1:0]  i_expected,
    output logic              o_match
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    crc_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_en, w_en_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [CRC_W-1:0]  r_crc, w_crc_nxt;
    logic [CRC_W-1:0]  r_crc_out, w_crc_out_nxt;
    logic [RD_LAT-1:0] r_vld, w_vld_nxt, w_vld_shift;
    logic [CRC_W-1:0]  w_crc_step, w_crc_fold, w_final_src, w_crc_final;
`ifdef CRC_CHECK_EN
    logic              r_match, w_match_nxt;
`endif

    crc_byte_lfsr #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .REFIN (REFIN)
    ) u_lfsr (
        .i_crc   (r_crc),
        .i_data  (i_bram_dout),
        .o_crc_c (w_crc_step)
    );

    // Tail of the valid pipeline marks the cycle a requested byte is on i_bram_dout.
    assign w_vld_shift = RD_LAT'({r_vld, r_en});
    assign w_crc_fold  = r_vld[RD_LAT-1] ? w_crc_step : r_crc;
    assign w_final_src = (r_state == ST_IDLE) ? INIT : w_crc_fold;

    always_comb begin
        w_crc_final = w_final_src;
        if (REFOUT) begin
            w_crc_final = CRC_W'(bit_rev(CRC_MAX_W'(w_final_src), CRC_W));
        end
        w_crc_final = w_crc_final ^ XOROUT;
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_en_nxt      = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_crc_nxt     = w_crc_fold;
        w_crc_out_nxt = r_crc_out;
        w_vld_nxt     = w_vld_shift;
`ifdef CRC_CHECK_EN
        w_match_nxt   = r_match;
`endif

        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_crc_nxt  = INIT;
                    w_busy_nxt = 1'b1;
`ifdef CRC_CHECK_EN
                    w_match_nxt = 1'b0;
`endif
                    if (i_len != '0) begin
                        w_state_nxt = ST_ISSUE;
                        w_addr_nxt  = i_base_addr;
                        w_en_nxt    = 1'b1;
                        w_cnt_nxt   = i_len - CNT_W'(1);
                    end else begin
                        w_state_nxt   = ST_FINISH;
                        w_done_nxt    = 1'b1;
                        w_crc_out_nxt = w_crc_final;
`ifdef CRC_CHECK_EN
                        w_match_nxt = (w_crc_final == i_expected);
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (r_cnt != '0) begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_en_nxt   = 1'b1;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish as the last outstanding byte is folded in.
                if (w_vld_shift == '0) begin
                    w_state_nxt   = ST_FINISH;
                    w_done_nxt    = 1'b1;
                    w_crc_out_nxt = w_crc_final;
`ifdef CRC_CHECK_EN
                    w_match_nxt = (w_crc_final == i_expected);
`endif
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_en_nxt      = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_vld_nxt     = '0;
            w_crc_out_nxt = r_crc_out;
`ifdef CRC_CHECK_EN
            w_match_nxt   = r_match;
`endif
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_crc     <= INIT;
            r_crc_out <= '0;
            r_vld     <= '0;
`ifdef CRC_CHECK_EN
            r_match   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_en      <= w_en_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_crc     <= w_crc_nxt;
            r_crc_out <= w_crc_out_nxt;
            r_vld     <= w_vld_nxt;
`ifdef CRC_CHECK_EN
            r_match   <= w_match_nxt;
`endif
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_crc       = r_crc_out;
    assign o_bram_addr = r_addr;
    assign o_bram_en   = r_en;
`ifdef CRC_CHECK_EN
    assign o_match     = r_match;
`endif

endmodule

// File: tb/tb_crc_bram_engine.sv
// Scoreboard bench for crc_bram_engine: four configurations (CCITT RD_LAT 2/1/4,
// reflected CRC-32) sharing one BRAM image. Honours CRC_CHECK_EN when defined.
module tb_crc_bram_engine;

    typedef struct {
        int          dut;
        logic [31:0] crc;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         en_cnt = 0;

    logic [7:0] mem [512];
    logic [7:0] pipe [4][4];
    logic [7:0] dout [4];
    logic       start [4];
    logic       abort [4];
    logic [8:0] base [4];
    logic [9:0] len [4];
    logic       busy [4];
    logic       done [4];
    logic [8:0] addr [4];
    logic       en [4];
    logic [15:0] crc_d, crc_l1, crc_l4;
    logic [31:0] crc_32;
    logic [31:0] crc_all [4];
    exp_t       exp_q[$];
    logic [8:0] addr_q[$];
`ifdef CRC_CHECK_EN
    logic [15:0] expected_d;
    logic        match [4];
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (en[0]) en_cnt <= en_cnt + 1;

    function automatic int lat_of(input int k);
        case (k)
            2:       return 1;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    // Registered BRAM read followed by extra delay stages per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            pipe[k][0] <= mem[addr[k]];
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) dout[k] = pipe[k][lat_of(k)-1];
    end

    assign crc_all[0] = {16'h0, crc_d};
    assign crc_all[1] = crc_32;
    assign crc_all[2] = {16'h0, crc_l1};
    assign crc_all[3] = {16'h0, crc_l4};

    crc_bram_engine u_d (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_start(start[0]), .i_abort(abort[0]),
        .i_base_addr(base[0]), .i_len(len[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_crc(crc_d), .o_bram_addr(addr[0]), .o_bram_en(en[0]), .i_bram_dout(dout[0])
`ifdef CRC_CHECK_EN
        , .i_expected(expected_d), .o_match(match[0])
`endif
    );

    crc_bram_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
        .REFIN(1'b1), .REFOUT(1'b1)
    ) u_c32 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_start(start[1]), .i_abort(abort[1]),
        .i_base_addr(base[1]), .i_len(len[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_crc(crc_32), .o_bram_addr(addr[1]), .o_bram_en(en[1]), .i_bram_dout(dout[1])
`ifdef CRC_CHECK_EN
        , .i_expected(32'hCBF43926), .o_match(match[1])
`endif
    );

    crc_bram_engine #(.RD_LAT(1)) u_l1 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_start(start[2]), .i_abort(abort[2]),
        .i_base_addr(base[2]), .i_len(len[2]), .o_busy(busy[2]), .o_done(done[2]),
        .o_crc(crc_l1), .o_bram_addr(addr[2]), .o_bram_en(en[2]), .i_bram_dout(dout[2])
`ifdef CRC_CHECK_EN
        , .i_expected(16'h29B1), .o_match(match[2])
`endif
    );

    crc_bram_engine #(.RD_LAT(4)) u_l4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_start(start[3]), .i_abort(abort[3]),
        .i_base_addr(base[3]), .i_len(len[3]), .o_busy(busy[3]), .o_done(done[3]),
        .o_crc(crc_l4), .o_bram_addr(addr[3]), .o_bram_en(en[3]), .i_bram_dout(dout[3])
`ifdef CRC_CHECK_EN
        , .i_expected(16'h29B1), .o_match(match[3])
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: completion pulses and dut0 read addresses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (done[k]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(k), 64'hFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_dut", 64'(k), 64'(e.dut));
                        check("crc", 64'(crc_all[k]), 64'(e.crc));
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
            if (en[0]) begin
                if (addr_q.size() == 0) check("bram_en_unexpected", 64'(1), 64'(0));
                else check("bram_addr", 64'(addr[0]), 64'(addr_q.pop_front()));
            end
        end
    end

    task automatic load_msg(input int b);
        string s = "123456789";
        for (int i = 0; i < 9; i++) mem[9'(b + i)] = s[i];
    endtask

    task automatic push_addrs(input int b, input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(9'(b + i));
    endtask

    task automatic kick(input int k, input int b, input int n, input logic [31:0] crc);
        exp_t e;
        @(negedge clk);
        e.dut = k;
        e.crc = crc;
        e.cyc = cyc + ((n == 0) ? 1 : n + lat_of(k) + 1);
        exp_q.push_back(e);
        if (k == 0) push_addrs(b, n);
        base[k]  = 9'(b);
        len[k]   = 10'(n);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("done_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0; abort[k] = 1'b0; base[k] = '0; len[k] = '0;
        end
`ifdef CRC_CHECK_EN
        expected_d = 16'h29B1;
`endif
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        load_msg(0);
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy[0]), 0);
        check("rst_done", 64'(done[0]), 0);
        check("rst_en", 64'(en[0]), 0);
        check("rst_addr", 64'(addr[0]), 0);
        check("rst_crc32", 64'(crc_32), 0);
        rst_n = 1'b1;
        @(negedge clk);

        kick(0, 0, 9, 32'h29B1);
        check("busy_after_start", 64'(busy[0]), 1);
        wait_drain();
        check("busy_idle", 64'(busy[0]), 0);
`ifdef CRC_CHECK_EN
        check("match_hit", 64'(match[0]), 1);
`endif

        load_msg(9'h1FE);
        kick(0, 9'h1FE, 9, 32'h29B1);
        wait_drain();
        load_msg(0);

        kick(1, 0, 9, 32'hCBF43926);
        wait_drain();
        kick(2, 0, 9, 32'h29B1);
        wait_drain();
        kick(3, 0, 9, 32'h29B1);
        wait_drain();

        e0 = en_cnt;
`ifdef CRC_CHECK_EN
        expected_d = 16'h29B0;
`endif
        kick(0, 0, 0, 32'hFFFF);
        wait_drain();
        check("len0_no_en", 64'(en_cnt - e0), 0);
`ifdef CRC_CHECK_EN
        check("match_miss", 64'(match[0]), 0);
        expected_d = 16'h29B1;
`endif

        // Abort in cycle 4: four reads issued, no completion, o_crc held.
        @(negedge clk);
        push_addrs(0, 4);
        base[0] = '0; len[0] = 10'd9; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        check("abort_busy", 64'(busy[0]), 0);
        check("abort_en", 64'(en[0]), 0);
        check("abort_crc_held", 64'(crc_d), 64'hFFFF);
        repeat (15) @(negedge clk);
        check("abort_addr_q", 64'(addr_q.size()), 0);

        // Start with abort in IDLE: nothing starts.
        start[0] = 1'b1; abort[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; abort[0] = 1'b0;
        check("abort_wins_busy", 64'(busy[0]), 0);
        check("abort_wins_en", 64'(en[0]), 0);

        // Restart with stray starts while busy and in the done cycle.
        kick(0, 0, 9, 32'h29B1);
        base[0] = 9'h100; len[0] = 10'd3; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int i = 0; i < 40 && !done[0]; i++) @(negedge clk);
        check("done_seen", 64'(done[0]), 1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("start_in_finish", 64'(busy[0]), 0);
        wait_drain();
        check("finish_start_en", 64'(en[0]), 0);

        // Asynchronous reset mid-run: immediate clear, no completion.
        @(negedge clk);
        push_addrs(0, 9);
        base[0] = '0; len[0] = 10'd9; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy[0]), 0);
        check("arst_en", 64'(en[0]), 0);
        check("arst_addr", 64'(addr[0]), 0);
        check("arst_crc", 64'(crc_d), 0);
        addr_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("arst_no_done_q", 64'(exp_q.size()), 0);

        kick(0, 0, 9, 32'h29B1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
